// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory-wait timeout and sticky illegal/timeout trap.
module multicycle_control #(
  parameter int MEM_WAIT_MAX  = 15,
  parameter bit EN_JALR_AUIPC = 1'b1,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       branch_taken,
  output logic       imem_req,
  output logic       ir_write,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MEM_WAIT_MAX);

  state_t           state_q, state_d;
  logic [6:0]       opcode_q;
  logic [CNT_W-1:0] wait_cnt, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             at_limit;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_JAL, OP_BRANCH: return 1'b1;
      OP_AUIPC, OP_JALR: return EN_JALR_AUIPC;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_cnt  <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
    end
  end

  assign at_limit = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LIM);

  // Handshake: imem_req/dmem_req stay high until the matching ready is seen at a rising
  // edge; the transfer completes on that edge. wait_cnt counts only stalled request cycles.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'b00;
    wb_sel    = 2'd0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (at_limit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R:     begin alu_op = 2'b10; state_d = S_WB; end
          OP_I:     begin alu_src_b = 2'd1; alu_op = 2'b10; state_d = S_WB; end
          OP_LOAD, OP_STORE: begin alu_src_b = 2'd1; state_d = S_MEM; end
          OP_LUI:   begin alu_src_a = 2'd2; alu_src_b = 2'd1; state_d = S_WB; end
          OP_AUIPC, OP_JAL: begin alu_src_a = 2'd1; alu_src_b = 2'd1; state_d = S_WB; end
          OP_JALR:  begin alu_src_b = 2'd1; state_d = S_WB; end
          OP_BRANCH: begin
            alu_op   = 2'b11;
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'd1 : 2'd0;
            state_d  = S_FETCH;
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_q == OP_STORE);
        if (dmem_ready) begin
          if (opcode_q == OP_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (at_limit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        if (opcode_q == OP_LOAD) wb_sel = 2'd1;
        if (opcode_q == OP_JAL || opcode_q == OP_JALR) begin
          wb_sel = 2'd2;
          pc_src = 2'd2;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Reset must never leak a request or strobe, even combinationally.
    if (rst) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      alu_op    = 2'b00;
      wb_sel    = 2'd0;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table for every opcode class, plus
// directed sequences for illegal trap, wait timeout, ready-on-limit and reset mid-MEM.
module tb_multicycle_control;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // strobe groups {imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write}
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_FRDY  = 6'b110000;
  localparam logic [5:0] S_FWAIT = 6'b100000;
  localparam logic [5:0] S_BR    = 6'b000001;
  localparam logic [5:0] S_LD    = 6'b001000;
  localparam logic [5:0] S_STDN  = 6'b001101;
  localparam logic [5:0] S_WB    = 6'b000011;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [6:0] opcode;
  logic       imem_ready, dmem_ready, branch_taken;

  logic       imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, illegal, timeout;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] state;
  logic       imem_req_n, ir_write_n, dmem_req_n, dmem_we_n, reg_write_n, pc_write_n;
  logic       illegal_n, timeout_n;
  logic [1:0] pc_src_n, alu_src_a_n, alu_src_b_n, alu_op_n, wb_sel_n;
  logic [2:0] state_n;
  logic [20:0] act, act_n;

  int checks = 0;
  int failures = 0;
  int n;

  typedef struct {
    logic [6:0]  opc;
    logic        ir;
    logic        dr;
    logic        bt;
    logic [20:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .wb_sel(wb_sel), .illegal(illegal), .timeout(timeout), .state(state)
  );

  multicycle_control #(.EN_JALR_AUIPC(1'b0)) dut_nj (
    .clk(clk), .rst(rst2), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req_n),
    .ir_write(ir_write_n), .dmem_req(dmem_req_n), .dmem_we(dmem_we_n),
    .reg_write(reg_write_n), .pc_write(pc_write_n), .pc_src(pc_src_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .alu_op(alu_op_n),
    .wb_sel(wb_sel_n), .illegal(illegal_n), .timeout(timeout_n), .state(state_n)
  );

  assign act = {state, imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write,
                pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, illegal, timeout};
  assign act_n = {state_n, imem_req_n, ir_write_n, dmem_req_n, dmem_we_n, reg_write_n,
                  pc_write_n, pc_src_n, alu_src_a_n, alu_src_b_n, alu_op_n, wb_sel_n,
                  illegal_n, timeout_n};

  function automatic logic [20:0] ex(input logic [2:0] st, input logic [5:0] s,
                                     input logic [1:0] ps, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] wb);
    return {st, s, ps, a, b, op, wb, 2'b00};
  endfunction

  function automatic void add(input logic [6:0] opc, input logic ir, input logic dr,
                              input logic bt, input logic [20:0] e);
    vec_t v;
    v.opc = opc; v.ir = ir; v.dr = dr; v.bt = bt; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    chk(name, {11'd0, act}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    opcode = '0; imem_ready = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b0;

    // fetch stall then R-type
    add(OP_R, 0, 1, 0, ex(0, S_FWAIT, 0, 0, 0, 2'b00, 0));
    add(OP_R, 0, 1, 0, ex(0, S_FWAIT, 0, 0, 0, 2'b00, 0));
    add(OP_R, 1, 1, 0, ex(0, S_FRDY,  0, 0, 0, 2'b00, 0));
    add(OP_R, 1, 1, 0, ex(1, S_NONE,  0, 0, 0, 2'b00, 0));
    add(OP_R, 1, 1, 0, ex(2, S_NONE,  0, 0, 0, 2'b10, 0));
    add(OP_R, 1, 1, 0, ex(4, S_WB,    0, 0, 0, 2'b00, 0));
    // I-type
    add(OP_I, 1, 1, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_I, 1, 1, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_I, 1, 1, 0, ex(2, S_NONE, 0, 0, 1, 2'b10, 0));
    add(OP_I, 1, 1, 0, ex(4, S_WB,   0, 0, 0, 2'b00, 0));
    // LOAD, dmem_ready low 3 cycles: 8 cycles total
    add(OP_LOAD, 1, 0, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_LOAD, 1, 0, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_LOAD, 1, 0, 0, ex(2, S_NONE, 0, 0, 1, 2'b00, 0));
    add(OP_LOAD, 1, 0, 0, ex(3, S_LD,   0, 0, 0, 2'b00, 0));
    add(OP_LOAD, 1, 0, 0, ex(3, S_LD,   0, 0, 0, 2'b00, 0));
    add(OP_LOAD, 1, 0, 0, ex(3, S_LD,   0, 0, 0, 2'b00, 0));
    add(OP_LOAD, 1, 1, 0, ex(3, S_LD,   0, 0, 0, 2'b00, 0));
    add(OP_LOAD, 1, 1, 0, ex(4, S_WB,   0, 0, 0, 2'b00, 1));
    // STORE
    add(OP_STORE, 1, 1, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_STORE, 1, 1, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_STORE, 1, 1, 0, ex(2, S_NONE, 0, 0, 1, 2'b00, 0));
    add(OP_STORE, 1, 1, 0, ex(3, S_STDN, 0, 0, 0, 2'b00, 0));
    // BRANCH taken, then not taken
    add(OP_BRANCH, 1, 1, 1, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_BRANCH, 1, 1, 1, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_BRANCH, 1, 1, 1, ex(2, S_BR,   1, 0, 0, 2'b11, 0));
    add(OP_BRANCH, 1, 1, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_BRANCH, 1, 1, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_BRANCH, 1, 1, 0, ex(2, S_BR,   0, 0, 0, 2'b11, 0));
    // LUI, AUIPC
    add(OP_LUI, 1, 1, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_LUI, 1, 1, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_LUI, 1, 1, 0, ex(2, S_NONE, 0, 2, 1, 2'b00, 0));
    add(OP_LUI, 1, 1, 0, ex(4, S_WB,   0, 0, 0, 2'b00, 0));
    add(OP_AUIPC, 1, 1, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_AUIPC, 1, 1, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_AUIPC, 1, 1, 0, ex(2, S_NONE, 0, 1, 1, 2'b00, 0));
    add(OP_AUIPC, 1, 1, 0, ex(4, S_WB,   0, 0, 0, 2'b00, 0));
    // JAL: opcode bus changes after DECODE, decode must come from the latched copy
    add(OP_JAL, 1, 1, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_JAL, 1, 1, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(7'h00,  1, 1, 0, ex(2, S_NONE, 0, 1, 1, 2'b00, 0));
    add(7'h00,  1, 1, 0, ex(4, S_WB,   2, 0, 0, 2'b00, 2));
    add(OP_JALR, 1, 1, 0, ex(0, S_FRDY, 0, 0, 0, 2'b00, 0));
    add(OP_JALR, 1, 1, 0, ex(1, S_NONE, 0, 0, 0, 2'b00, 0));
    add(OP_JALR, 1, 1, 0, ex(2, S_NONE, 0, 0, 1, 2'b00, 0));
    add(OP_JALR, 1, 1, 0, ex(4, S_WB,   2, 0, 0, 2'b00, 2));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_dut", {11'd0, act}, 32'd0);
    chk("reset_nj", {11'd0, act_n}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].opc; imem_ready = vecs[i].ir;
      dmem_ready = vecs[i].dr; branch_taken = vecs[i].bt;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {11'd0, act}, {11'd0, vecs[i].exp});
      tick();
    end

    // illegal opcode: sticky trap, no fetch requests until reset
    opcode = 7'h7f; imem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("illegal_trap", {27'd0, state, illegal, timeout}, {27'd0, 3'd5, 2'b10});
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      chk("trap_hold", {11'd0, act}, {11'd0, 3'd5, 16'd0, 2'b10});
    end
    do_reset("rst_after_illegal");

    // fetch timeout: 16 stalled FETCH cycles then TRAP
    imem_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state == 3'd5) break;
      if (state == 3'd0) n++;
      tick();
    end
    chk("fetch_timeout_cycles", n, 16);
    chk("fetch_timeout_flags", {27'd0, state, illegal, timeout}, {27'd0, 3'd5, 2'b01});
    do_reset("rst_after_timeout");

    // ready arriving on the limit cycle wins
    imem_ready = 1'b0;
    repeat (15) tick();
    imem_ready = 1'b1; opcode = OP_LOAD; dmem_ready = 1'b0;
    @(negedge clk);
    chk("limit_ready_irw", {28'd0, state, ir_write}, {28'd0, 3'd0, 1'b1});
    tick();
    imem_ready = 1'b0;
    @(negedge clk);
    chk("limit_ready_state", {28'd0, state, timeout}, {28'd0, 3'd1, 1'b0});

    // data memory timeout on the same LOAD
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state == 3'd5) break;
      if (state == 3'd3) n++;
      tick();
    end
    chk("mem_timeout_cycles", n, 16);
    chk("mem_timeout_flags", {27'd0, state, illegal, timeout}, {27'd0, 3'd5, 2'b01});

    // JALR/AUIPC disabled instance; the default instance is parked in reset
    rst = 1'b1;
    #1;
    chk("rst_park", {11'd0, act}, 32'd0);
    tick();
    rst2 = 1'b0;
    opcode = OP_JALR; imem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("nj_jalr_illegal", {28'd0, state_n, illegal_n}, {28'd0, 3'd5, 1'b1});
    rst2 = 1'b1;
    #1;
    chk("nj_rst1", {11'd0, act_n}, 32'd0);
    tick();
    rst2 = 1'b0;
    opcode = OP_AUIPC;
    tick();
    tick();
    @(negedge clk);
    chk("nj_auipc_illegal", {28'd0, state_n, illegal_n}, {28'd0, 3'd5, 1'b1});
    rst2 = 1'b1;
    #1;
    chk("nj_rst2", {11'd0, act_n}, 32'd0);
    tick();
    rst2 = 1'b0;

    // reset asserted mid-MEM clears everything at once
    opcode = OP_LOAD; dmem_ready = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("nj_in_mem", {11'd0, act_n}, {11'd0, ex(3, S_LD, 0, 0, 0, 2'b00, 0)});
    tick();
    rst2 = 1'b1;
    #1;
    chk("nj_rst_mid_mem", {11'd0, act_n}, 32'd0);
    tick();
    rst2 = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    chk("nj_after_rst", {11'd0, act_n}, {11'd0, ex(0, S_FWAIT, 0, 0, 0, 2'b00, 0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
